// File: rtl/mem_responder.sv
// Single-port word memory responder for the multicycle CPU memory port.
// Serves one read or write per request after WAIT_CYCLES wait states and flags illegal requests.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        busy
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic             wr_q;
   logic             err_q;
   logic [31:0]      rdata_q;
   logic             ready_q;
   logic             merr_q;
   logic             busy_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             req_c;
   logic             req_err_c;
   logic [IDX_W-1:0] req_idx_c;
   logic             go_resp_c;
   logic             op_wr_c;
   logic             op_err_c;
   logic [IDX_W-1:0] op_idx_c;
   logic [31:0]      op_wdata_c;

   // With no wait states the response edge is the capture edge, so the live request is used there.
   always_comb begin
      req_c      = mem_rd | mem_wr;
      req_err_c  = (mem_rd & mem_wr) | (addr[1:0] != 2'b00) | (addr[31:IDX_W+2] != '0);
      req_idx_c  = addr[IDX_W+1:2];
      go_resp_c  = ((state_q == S_IDLE) & req_c & NO_WAIT) |
                   ((state_q == S_WAIT) & (cnt_q == CNT_W'(1)));
      op_wr_c    = wr_q;
      op_err_c   = err_q;
      op_idx_c   = idx_q;
      op_wdata_c = wdata_q;
      if (state_q == S_IDLE) begin
         op_wr_c    = mem_wr;
         op_err_c   = req_err_c;
         op_idx_c   = req_idx_c;
         op_wdata_c = wdata;
      end
   end

   // Request FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         merr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         merr_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_c) begin
                  idx_q   <= req_idx_c;
                  wdata_q <= wdata;
                  wr_q    <= mem_wr;
                  err_q   <= req_err_c;
                  busy_q  <= 1'b1;
                  cnt_q   <= WAIT_LD;
                  state_q <= NO_WAIT ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= S_RESP;
            end
            S_RESP: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         if (go_resp_c) begin
            ready_q <= 1'b1;
            merr_q  <= op_err_c;
            if (op_err_c) rdata_q <= '0;
            else if (!op_wr_c) rdata_q <= mem[op_idx_c];
         end
      end
   end

   // Array is not reset; a write aborted by reset never reaches the response edge.
   always_ff @(posedge clk) begin
      if (rst_n && go_resp_c && op_wr_c && !op_err_c) mem[op_idx_c] <= op_wdata_c;
   end

   assign rdata     = rdata_q;
   assign mem_ready = ready_q;
   assign mem_err   = merr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WA    = 2;
   localparam int unsigned WB    = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        rd_s    [2];
   logic        wr_s    [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wdata_s [2];
   logic [31:0] rdata_s [2];
   logic        ready_s [2];
   logic        err_s   [2];
   logic        busy_s  [2];

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA), .INIT_FILE("")) dut_a (
      .clk(clk), .rst_n(rst_n), .mem_rd(rd_s[0]), .mem_wr(wr_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .rdata(rdata_s[0]), .mem_ready(ready_s[0]), .mem_err(err_s[0]),
      .busy(busy_s[0]));

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB), .INIT_FILE("")) dut_b (
      .clk(clk), .rst_n(rst_n), .mem_rd(rd_s[1]), .mem_wr(wr_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .rdata(rdata_s[1]), .mem_ready(ready_s[1]), .mem_err(err_s[1]),
      .busy(busy_s[1]));

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sbq_a[$];
   exp_t        sbq_b[$];
   logic [31:0] mdl     [2][DEPTH];
   logic [31:0] last_rd [2];
   int          n_vec = 0;
   int          n_err = 0;
   int          ncnt  = 0;
   int          start [2];
   logic        bprev [2];
   logic        rprev [2];

   function automatic int unsigned wc(int d);
      return (d == 0) ? WA : WB;
   endfunction

   // Reference behaviour: word memory indexed by addr/4, illegal requests return zero.
   function automatic exp_t model_op(int d, logic rd, logic wr, logic [31:0] a, logic [31:0] wd);
      exp_t e;
      longint unsigned ua = a;
      e.err = (rd && wr) || (a % 4 != 0) || (ua >= 4 * DEPTH);
      if (e.err) last_rd[d] = 32'h0;
      else if (rd) last_rd[d] = mdl[d][a / 4];
      else mdl[d][a / 4] = wd;
      e.rdata = last_rd[d];
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(int d, exp_t e);
      if (d == 0) sbq_a.push_back(e);
      else sbq_b.push_back(e);
   endtask

   task automatic mon(int d);
      exp_t e;
      bit   have = 1'b0;
      if (rprev[d]) check($sformatf("busy_drop%0d", d), 32'(busy_s[d]), 32'h0);
      if (busy_s[d] && !bprev[d]) start[d] = ncnt;
      if (ready_s[d]) begin
         if (d == 0 && sbq_a.size() > 0) begin e = sbq_a.pop_front(); have = 1'b1; end
         if (d == 1 && sbq_b.size() > 0) begin e = sbq_b.pop_front(); have = 1'b1; end
         if (!have) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready dut%0d: got ready=1 expected no response", d);
         end else begin
            check($sformatf("err%0d", d), 32'(err_s[d]), 32'(e.err));
            check($sformatf("rdata%0d", d), rdata_s[d], e.rdata);
            check($sformatf("latency%0d", d), 32'(ncnt - start[d]), 32'(wc(d)));
            check($sformatf("busy_at_ready%0d", d), 32'(busy_s[d]), 32'h1);
         end
      end else begin
         check($sformatf("err_no_ready%0d", d), 32'(err_s[d]), 32'h0);
      end
      bprev[d] = busy_s[d];
      rprev[d] = ready_s[d];
   endtask

   // Monitor: compares every ready pulse against the scoreboard.
   always @(negedge clk) begin
      ncnt++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            bprev[d] = 1'b0;
            rprev[d] = 1'b0;
         end else begin
            mon(d);
         end
      end
   end

   task automatic issue(int d, logic rd, logic wr, logic [31:0] a, logic [31:0] wd);
      bit done = 1'b0;
      @(negedge clk);
      rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wdata_s[d] = wd;
      push(d, model_op(d, rd, wr, a, wd));
      @(posedge clk);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (ready_s[d]) begin
            rd_s[d] = 1'b0; wr_s[d] = 1'b0;
            done = 1'b1;
         end else begin
            rd_s[d] = 1'($urandom); wr_s[d] = 1'($urandom);
            addr_s[d] = $urandom; wdata_s[d] = $urandom;
         end
      end
      if (!done) begin
         n_vec++; n_err++;
         rd_s[d] = 1'b0; wr_s[d] = 1'b0;
         $display("FAIL ready_timeout dut%0d: got no ready expected one within 40 cycles", d);
      end
   endtask

   task automatic rand_op(int d);
      int unsigned k = $urandom_range(0, 9);
      logic [31:0] a = 32'($urandom_range(0, DEPTH - 1) * 4);
      logic        rd = (k <= 3);
      logic        wr = (k >= 4 && k <= 6);
      if (k == 7) a = a | 32'($urandom_range(1, 3));
      if (k == 8) a = ($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH) : (32'($urandom) | 32'h8000_0000);
      if (k == 7 || k == 8) begin rd = 1'($urandom); wr = !rd; end
      if (k == 9) begin rd = 1'b1; wr = 1'b1; end
      issue(d, rd, wr, a, $urandom);
   endtask

   task automatic check_reset_outputs(string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_rdata%0d", tag, d), rdata_s[d], 32'h0);
         check($sformatf("%s_ready%0d", tag, d), 32'(ready_s[d]), 32'h0);
         check($sformatf("%s_err%0d", tag, d), 32'(err_s[d]), 32'h0);
         check($sformatf("%s_busy%0d", tag, d), 32'(busy_s[d]), 32'h0);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
         last_rd[d] = '0; start[d] = 0; bprev[d] = 1'b0; rprev[d] = 1'b0;
      end
      #1 rst_n = 1'b0;
      #20 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) issue(d, 1'b0, 1'b1, 32'(i * 4), $urandom);

      // Two wait states: write then read back, misaligned write, range edges, rd+wr conflict.
      issue(0, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF);
      issue(0, 1'b1, 1'b0, 32'h08, 32'h0);
      issue(0, 1'b0, 1'b1, 32'h0A, 32'h1234_5678);
      issue(0, 1'b1, 1'b0, 32'h08, 32'h0);
      issue(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
      issue(0, 1'b1, 1'b0, 32'(4 * DEPTH - 4), 32'h0);
      issue(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
      issue(0, 1'b1, 1'b0, 32'h0, 32'h0);

      // Reset in the middle of a write's wait states aborts it.
      @(negedge clk);
      rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = ~mdl[0][4];
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      wr_s[0] = 1'b0;
      #1 check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
      issue(0, 1'b1, 1'b0, 32'h10, 32'h0);

      // No wait states, mem_rd held: capture and response alternate.
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("b2b_ready_pattern", 32'(ready_s[1]), 32'(j % 2));
         if (j % 2 == 0) begin
            rd_s[1] = 1'b1; wr_s[1] = 1'b0;
            addr_s[1] = ((j / 2) % 2 == 1) ? 32'h4 : 32'h0;
            push(1, model_op(1, 1'b1, 1'b0, addr_s[1], 32'h0));
         end
      end
      rd_s[1] = 1'b0;
      issue(1, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
      issue(1, 1'b1, 1'b0, 32'(4 * DEPTH - 4), 32'h0);

      for (int i = 0; i < 120; i++) rand_op(0);
      for (int i = 0; i < 80; i++) rand_op(1);

      repeat (6) @(negedge clk);
      check("sb_a_drained", 32'(sbq_a.size()), 32'h0);
      check("sb_b_drained", 32'(sbq_b.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
